// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage definitions (package cpu_defs_pkg): state encoding,
// PC increment, NOP encoding and default reset PC.
package cpu_defs_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] INST_NOP         = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Word-align a byte address (low two bits forced to zero).
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: ROM read port, execute redirect and IF/ID handshake to
// decode. master = fetch stage, slave = its environment (ROM/decode/execute).
interface inst_fetch_if #(
    parameter int unsigned ADDR_W = 5
);
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_inst;
    logic              id_ready;
    logic              redirect_valid;
    logic [31:0]       redirect_target;
    logic              if_valid;
    logic [31:0]       if_inst;
    logic [31:0]       if_pc;

    modport master (
        output rom_addr,
        input  rom_inst,
        input  id_ready,
        input  redirect_valid,
        input  redirect_target,
        output if_valid,
        output if_inst,
        output if_pc
    );

    modport slave (
        input  rom_addr,
        output rom_inst,
        output id_ready,
        output redirect_valid,
        output redirect_target,
        input  if_valid,
        input  if_inst,
        input  if_pc
    );
endinterface

// File: rtl/inst_fetch_if_id_reg.sv
// IF/ID output register: valid flag plus instruction and its byte PC.
// clear has priority over load; otherwise contents are held.
module if_id_reg
    import cpu_defs_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    output logic        valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o
);
    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;

    // Next-state: clear drops only the valid flag, load captures a new entry.
    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            inst_d  = inst_i;
            pc_d    = pc_i;
        end
    end

    // Register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            inst_q  <= INST_NOP;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = inst_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC register, next-PC mux and fetch FSM; drives the
// async ROM address and fills the IF/ID register under a valid/ready handshake.
// Optional feature macro: FETCH_PERF_CNT_EN adds the fetch_count port/counter.
module inst_fetch
    import cpu_defs_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned ADDR_W   = 5
) (
    input  logic        clk,
    input  logic        resetn,
    inst_fetch_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);
    fetch_state_e state_q;
    logic [31:0]  pc_q, pc_d;
    logic         issue;
    logic         ifid_load;
    logic         ifid_clear;

    // Issue/redirect decode and IF/ID control (redirect wins over everything).
    always_comb begin
        issue      = (state_q != S_IDLE) && (!bus.if_valid || bus.id_ready)
                     && !bus.redirect_valid;
        ifid_load  = issue;
        ifid_clear = bus.redirect_valid || (!issue && bus.if_valid && bus.id_ready);
    end

    // Next-PC mux.
    always_comb begin
        pc_d = pc_q;
        if (bus.redirect_valid) begin
            pc_d = align_word(bus.redirect_target);
        end else if (issue) begin
            pc_d = pc_q + PC_INC;
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Fetch FSM. RUN->STALL is taken once the issued entry is seen unaccepted
    // (if_valid && !id_ready), the only condition under which issue is blocked.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else if (bus.redirect_valid) begin
            state_q <= S_RUN;
        end else begin
            unique case (state_q)
                S_IDLE:  state_q <= S_RUN;
                S_RUN:   if (bus.if_valid && !bus.id_ready) state_q <= S_STALL;
                S_STALL: if (bus.id_ready) state_q <= S_RUN;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.rom_addr = pc_q[ADDR_W+1:2];

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .resetn  (resetn),
        .load_i  (ifid_load),
        .clear_i (ifid_clear),
        .inst_i  (bus.rom_inst),
        .pc_i    (pc_q),
        .valid_o (bus.if_valid),
        .inst_o  (bus.if_inst),
        .pc_o    (bus.if_pc)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;

    // Issue counter; wraps naturally, unaffected by redirects.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            fetch_cnt_q <= '0;
        end else if (issue) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
        end
    end

    assign fetch_count = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed stimulus pushes expected accepted
// instructions into a scoreboard; a negedge monitor pops on each handshake.
module tb_inst_fetch;
    import cpu_defs_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    inst_fetch_if #(.ADDR_W(5)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif

    inst_fetch #(.RESET_PC(32'h0000_0000), .ADDR_W(5)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .bus         (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count (fetch_count)
`endif
    );

    logic [31:0] rom [32];
    assign bus.rom_inst = rom[bus.rom_addr];

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] p, input logic [31:0] i);
        exp_t e;
        e.pc   = p;
        e.inst = i;
        sb.push_back(e);
    endtask

    // Monitor: every accepted IF/ID entry must match the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (resetn === 1'b1 && bus.if_valid === 1'b1 && bus.id_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL hs_unexpected: got pc %h expected no handshake", bus.if_pc);
            end else begin
                e = sb.pop_front();
                chk("hs_pc", bus.if_pc, e.pc);
                chk("hs_inst", bus.if_inst, e.inst);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 32'hC0DE_0000 | i;
        rom[0] = 32'h2401_0001;
        rom[1] = 32'h0001_1100;

        resetn              = 1'b0;
        bus.id_ready        = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'h0;
        step();
        step();
        chk("rst_valid", {31'h0, bus.if_valid}, 32'h0);
        chk("rst_inst", bus.if_inst, 32'h0);
        chk("rst_pc", bus.if_pc, 32'h0);
        chk("rst_addr", {27'h0, bus.rom_addr}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_cnt", fetch_count, 32'h0);
`endif
        resetn = 1'b1;

        // Test 1: idle bubble then back-to-back fetch.
        step();
        chk("t1_bubble_valid", {31'h0, bus.if_valid}, 32'h0);
        chk("t1_bubble_addr", {27'h0, bus.rom_addr}, 32'h0);
        push(32'h0, 32'h2401_0001);
        push(32'h4, 32'h0001_1100);
        step();
        chk("t1_c2_inst", bus.if_inst, 32'h2401_0001);
        chk("t1_c2_pc", bus.if_pc, 32'h0);
        chk("t1_c2_addr", {27'h0, bus.rom_addr}, 32'h1);
        step();
        chk("t1_c3_inst", bus.if_inst, 32'h0001_1100);
        chk("t1_c3_pc", bus.if_pc, 32'h4);
        chk("t1_c3_addr", {27'h0, bus.rom_addr}, 32'h2);
        push(32'h8, 32'hC0DE_0002);
        step();
        chk("t2_pc8", bus.if_pc, 32'h8);

        // Test 2: three-cycle stall holds if_inst/if_pc and pc.
        bus.id_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t2_hold_pc", bus.if_pc, 32'h8);
            chk("t2_hold_inst", bus.if_inst, 32'hC0DE_0002);
            chk("t2_hold_addr", {27'h0, bus.rom_addr}, 32'h3);
            chk("t2_hold_valid", {31'h0, bus.if_valid}, 32'h1);
        end
        bus.id_ready = 1'b1;
        step();
        chk("t2_resume_pc", bus.if_pc, 32'hC);
        chk("t2_resume_inst", bus.if_inst, 32'hC0DE_0003);

        // Test 3: redirect during stall squashes the held entry.
        bus.id_ready = 1'b0;
        step();
        chk("t3_stall_pc", bus.if_pc, 32'hC);
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h0000_0036;
        step();
        chk("t3_redir_valid", {31'h0, bus.if_valid}, 32'h0);
        chk("t3_redir_addr", {27'h0, bus.rom_addr}, 32'd13);
        bus.redirect_valid = 1'b0;
        bus.id_ready       = 1'b1;
        push(32'h34, 32'hC0DE_000D);
        step();
        chk("t3_target_pc", bus.if_pc, 32'h34);
        chk("t3_target_valid", {31'h0, bus.if_valid}, 32'h1);

        // Test 4: ROM address wraps 31 -> 0, if_pc keeps full value.
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h0000_0078;
        step();
        chk("t4_redir_valid", {31'h0, bus.if_valid}, 32'h0);
        chk("t4_addr30", {27'h0, bus.rom_addr}, 32'd30);
        bus.redirect_valid = 1'b0;
        push(32'h78, 32'hC0DE_001E);
        push(32'h7C, 32'hC0DE_001F);
        push(32'h80, 32'h2401_0001);
        step();
        chk("t4_pc78", bus.if_pc, 32'h78);
        chk("t4_addr31", {27'h0, bus.rom_addr}, 32'd31);
        step();
        chk("t4_pc7c", bus.if_pc, 32'h7C);
        chk("t4_addr0", {27'h0, bus.rom_addr}, 32'd0);
        step();
        chk("t4_pc80", bus.if_pc, 32'h80);
        chk("t4_inst80", bus.if_inst, 32'h2401_0001);
        chk("t4_addr1", {27'h0, bus.rom_addr}, 32'd1);
        step();
        chk("t4_pc84", bus.if_pc, 32'h84);

        // Test 5: reset mid-stall discards the held entry.
        bus.id_ready = 1'b0;
        step();
        chk("t5_hold_pc", bus.if_pc, 32'h84);
        chk("t5_hold_valid", {31'h0, bus.if_valid}, 32'h1);
`ifdef FETCH_PERF_CNT_EN
        chk("t5_cnt_before", fetch_count, 32'd9);
`endif
        resetn = 1'b0;
        step();
        chk("t5_rst_valid", {31'h0, bus.if_valid}, 32'h0);
        chk("t5_rst_pc", bus.if_pc, 32'h0);
        chk("t5_rst_addr", {27'h0, bus.rom_addr}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("t5_rst_cnt", fetch_count, 32'h0);
`endif
        resetn       = 1'b1;
        bus.id_ready = 1'b1;
        step();
        chk("t5_bubble_valid", {31'h0, bus.if_valid}, 32'h0);

        // Test 6: 10 issues around one redirect.
        for (int i = 0; i < 5; i++) begin
            push(32'(4 * i), rom[i]);
            step();
            chk("t6_a_pc", bus.if_pc, 32'(4 * i));
        end
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h0000_0040;
        step();
        chk("t6_redir_valid", {31'h0, bus.if_valid}, 32'h0);
        bus.redirect_valid = 1'b0;
        for (int j = 0; j < 5; j++) begin
            push(32'h40 + 32'(4 * j), rom[16 + j]);
            step();
            chk("t6_b_pc", bus.if_pc, 32'h40 + 32'(4 * j));
        end
`ifdef FETCH_PERF_CNT_EN
        chk("t6_cnt", fetch_count, 32'd10);
`endif
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h0;
        step();
        step();
        chk("t6_end_valid", {31'h0, bus.if_valid}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("t6_cnt_after_redir", fetch_count, 32'd10);
`endif
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
